// File: rtl/complex_butterfly_pipe.sv
// Three-stage pipelined radix-2 DIT butterfly: X = E + W*O, Y = E - W*O.
// Stage 1 registers the four partial products and E. Stage 2 forms the
// twiddled odd term and the sum/difference. Stage 3 rounds, saturates and
// drives the outputs. One global enable (advance) moves the whole pipe, so
// a stalled output freezes every stage.
module complex_butterfly_pipe #(
  parameter int DATA_WIDTH = 8,
  parameter int ODD_FRAC   = 5,
  parameter int EVEN_FRAC  = 6,
  parameter int TW_WIDTH   = 8,
  parameter int TW_FRAC    = 6,
  parameter int OUT_WIDTH  = 9,
  parameter int OUT_FRAC   = 5,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic                         in_last,
  input  logic                         inv_mode,
  input  logic                         scale_mode,
  input  logic signed [DATA_WIDTH-1:0] a_real,
  input  logic signed [DATA_WIDTH-1:0] a_imag,
  input  logic signed [DATA_WIDTH-1:0] even_r,
  input  logic signed [DATA_WIDTH-1:0] even_i,
  input  logic signed [TW_WIDTH-1:0]   b_real,
  input  logic signed [TW_WIDTH-1:0]   b_imag,
  output logic signed [OUT_WIDTH-1:0]  add_real,
  output logic signed [OUT_WIDTH-1:0]  add_imag,
  output logic signed [OUT_WIDTH-1:0]  sub_real,
  output logic signed [OUT_WIDTH-1:0]  sub_imag,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic                         out_last,
  output logic                         out_sat,
  output logic [CNT_WIDTH-1:0]         sat_cnt,
  input  logic                         sat_clr
);

  // Binary point of the products, alignment shift for E, and the base
  // output shift (one more when scale_mode is set).
  localparam int PF  = ODD_FRAC + TW_FRAC;
  localparam int ESH = PF - EVEN_FRAC;
  localparam int SH0 = PF - OUT_FRAC;
  // Product, sum/difference and rounding widths.
  localparam int PW  = DATA_WIDTH + TW_WIDTH + 1;
  localparam int SW  = DATA_WIDTH + TW_WIDTH + 3;
  localparam int RW  = SW + 1;

  localparam logic signed [OUT_WIDTH-1:0] OUT_MAX = {1'b0, {(OUT_WIDTH-1){1'b1}}};
  localparam logic signed [OUT_WIDTH-1:0] OUT_MIN = {1'b1, {(OUT_WIDTH-1){1'b0}}};

  // Reject formats the datapath cannot align or round.
  if (ESH < 0) begin : g_bad_esh
    $error("complex_butterfly_pipe: EVEN_FRAC exceeds ODD_FRAC + TW_FRAC");
  end
  if (SH0 < 1) begin : g_bad_sh
    $error("complex_butterfly_pipe: OUT_FRAC must be below ODD_FRAC + TW_FRAC");
  end

  typedef struct packed {
    logic                         last;
    logic                         scale;
    logic signed [PW-1:0]         p0;
    logic signed [PW-1:0]         p1;
    logic signed [PW-1:0]         p2;
    logic signed [PW-1:0]         p3;
    logic signed [DATA_WIDTH-1:0] e_r;
    logic signed [DATA_WIDTH-1:0] e_i;
  } s1_t;

  typedef struct packed {
    logic                 last;
    logic                 scale;
    logic signed [SW-1:0] sum_r;
    logic signed [SW-1:0] sum_i;
    logic signed [SW-1:0] dif_r;
    logic signed [SW-1:0] dif_i;
  } s2_t;

  typedef struct packed {
    logic                        last;
    logic                        sat;
    logic signed [OUT_WIDTH-1:0] add_r;
    logic signed [OUT_WIDTH-1:0] add_i;
    logic signed [OUT_WIDTH-1:0] sub_r;
    logic signed [OUT_WIDTH-1:0] sub_i;
  } s3_t;

  typedef struct packed {
    logic                        sat;
    logic signed [OUT_WIDTH-1:0] val;
  } rs_t;

  // Round half toward +inf, arithmetic shift, clamp to the output range.
  function automatic rs_t round_sat(input logic signed [SW-1:0] v, input logic scale);
    logic signed [RW-1:0] half;
    logic signed [RW-1:0] r;
    int unsigned          sh;
    rs_t                  res;
    sh   = scale ? SH0 + 1 : SH0;
    half = RW'(1) <<< (sh - 1);
    r    = (RW'(v) + half) >>> sh;
    if (r > RW'(OUT_MAX)) begin
      res.sat = 1'b1;
      res.val = OUT_MAX;
    end else if (r < RW'(OUT_MIN)) begin
      res.sat = 1'b1;
      res.val = OUT_MIN;
    end else begin
      res.sat = 1'b0;
      res.val = r[OUT_WIDTH-1:0];
    end
    return res;
  endfunction

  s1_t s1_d, s1_q;
  s2_t s2_d, s2_q;
  s3_t s3_d, s3_q;
  logic s1_valid_d, s1_valid_q;
  logic s2_valid_d, s2_valid_q;
  logic s3_valid_d, s3_valid_q;
  logic [CNT_WIDTH-1:0] sat_cnt_d, sat_cnt_q;

  logic                  advance;
  logic signed [TW_WIDTH:0] bi;
  logic signed [SW-1:0]  tr, ti, ee_r, ee_i;
  rs_t                   r_ar, r_ai, r_sr, r_si;

  // The whole pipe moves unless a finished sample is waiting on downstream.
  assign advance  = out_ready | ~s3_valid_q;
  assign in_ready = advance;

  // Stage 1: conditionally conjugate the twiddle, form the four products.
  always_comb begin
    // NOTE: combinational logic uses blocking '=' with every output given a
    // default first; sequential blocks below use non-blocking '<=' only.
    s1_d       = s1_q;
    s1_valid_d = s1_valid_q;
    bi         = (TW_WIDTH+1)'(b_imag);
    if (inv_mode) bi = -bi;
    if (advance) begin
      s1_valid_d = in_valid;
      if (in_valid) begin
        s1_d.last  = in_last;
        s1_d.scale = scale_mode;
        s1_d.p0    = PW'(a_real) * PW'(b_real);
        s1_d.p1    = PW'(a_imag) * PW'(bi);
        s1_d.p2    = PW'(a_real) * PW'(bi);
        s1_d.p3    = PW'(a_imag) * PW'(b_real);
        s1_d.e_r   = even_r;
        s1_d.e_i   = even_i;
      end
    end
  end

  // Stage 2: complete W*O, align E to the product binary point, add/subtract.
  always_comb begin
    s2_d       = s2_q;
    s2_valid_d = s2_valid_q;
    tr   = SW'($signed(s1_q.p0)) - SW'($signed(s1_q.p1));
    ti   = SW'($signed(s1_q.p2)) + SW'($signed(s1_q.p3));
    ee_r = SW'($signed(s1_q.e_r)) <<< ESH;
    ee_i = SW'($signed(s1_q.e_i)) <<< ESH;
    if (advance) begin
      s2_valid_d = s1_valid_q;
      if (s1_valid_q) begin
        s2_d.last  = s1_q.last;
        s2_d.scale = s1_q.scale;
        s2_d.sum_r = ee_r + tr;
        s2_d.sum_i = ee_i + ti;
        s2_d.dif_r = ee_r - tr;
        s2_d.dif_i = ee_i - ti;
      end
    end
  end

  // Stage 3: round and saturate each component, merge the clamp flags.
  always_comb begin
    s3_d       = s3_q;
    s3_valid_d = s3_valid_q;
    r_ar = round_sat(s2_q.sum_r, s2_q.scale);
    r_ai = round_sat(s2_q.sum_i, s2_q.scale);
    r_sr = round_sat(s2_q.dif_r, s2_q.scale);
    r_si = round_sat(s2_q.dif_i, s2_q.scale);
    if (advance) begin
      s3_valid_d = s2_valid_q;
      if (s2_valid_q) begin
        s3_d.last  = s2_q.last;
        s3_d.sat   = r_ar.sat | r_ai.sat | r_sr.sat | r_si.sat;
        s3_d.add_r = r_ar.val;
        s3_d.add_i = r_ai.val;
        s3_d.sub_r = r_sr.val;
        s3_d.sub_i = r_si.val;
      end
    end
  end

  // Saturation counter: clear wins, otherwise count saturated handshakes up to all-ones.
  always_comb begin
    sat_cnt_d = sat_cnt_q;
    if (sat_clr) begin
      sat_cnt_d = '0;
    end else if (s3_valid_q && out_ready && s3_q.sat && (sat_cnt_q != '1)) begin
      sat_cnt_d = sat_cnt_q + CNT_WIDTH'(1);
    end
  end

  // Control, output stage and counter registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_q <= 1'b0;
      s2_valid_q <= 1'b0;
      s3_valid_q <= 1'b0;
      s3_q       <= '0;
      sat_cnt_q  <= '0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s2_valid_q <= s2_valid_d;
      s3_valid_q <= s3_valid_d;
      s3_q       <= s3_d;
      sat_cnt_q  <= sat_cnt_d;
    end
  end

  // Internal datapath registers.
  always_ff @(posedge clk) begin
    // NOTE: no reset here; the stage valids qualify these, so clearing them
    // would only add reset fan-out to wide product/sum registers.
    s1_q <= s1_d;
    s2_q <= s2_d;
  end

  assign add_real  = s3_q.add_r;
  assign add_imag  = s3_q.add_i;
  assign sub_real  = s3_q.sub_r;
  assign sub_imag  = s3_q.sub_i;
  assign out_valid = s3_valid_q;
  assign out_last  = s3_q.last;
  assign out_sat   = s3_valid_q & s3_q.sat;
  assign sat_cnt   = sat_cnt_q;

endmodule

// File: tb/tb_complex_butterfly_pipe.sv
// Directed bench for complex_butterfly_pipe at default parameters.
module tb_complex_butterfly_pipe;

  logic              clk = 1'b0;
  logic              rst;
  logic              in_valid, in_ready, in_last, inv_mode, scale_mode;
  logic signed [7:0] a_real, a_imag, even_r, even_i, b_real, b_imag;
  logic signed [8:0] add_real, add_imag, sub_real, sub_imag;
  logic              out_valid, out_ready, out_last, out_sat, sat_clr;
  logic [15:0]       sat_cnt;

  int n_checks = 0;
  int n_pass   = 0;

  complex_butterfly_pipe dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_last(in_last),
    .inv_mode(inv_mode), .scale_mode(scale_mode),
    .a_real(a_real), .a_imag(a_imag), .even_r(even_r), .even_i(even_i),
    .b_real(b_real), .b_imag(b_imag),
    .add_real(add_real), .add_imag(add_imag), .sub_real(sub_real), .sub_imag(sub_imag),
    .out_valid(out_valid), .out_ready(out_ready), .out_last(out_last),
    .out_sat(out_sat), .sat_cnt(sat_cnt), .sat_clr(sat_clr)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic signed [31:0] obs,
                       input logic signed [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  // Present one sample with in_valid high, then move to the next negedge.
  task automatic drive(input int ar, ai, er, ei, br, bi, input logic inv, scl, lst);
    in_valid   = 1'b1;
    a_real     = 8'(ar);
    a_imag     = 8'(ai);
    even_r     = 8'(er);
    even_i     = 8'(ei);
    b_real     = 8'(br);
    b_imag     = 8'(bi);
    inv_mode   = inv;
    scale_mode = scl;
    in_last    = lst;
    @(negedge clk);
  endtask

  task automatic expect_out(input string tag, input int ar, ai, sr, si,
                            input logic sat, lst);
    check({tag, ".out_valid"}, out_valid, 1);
    check({tag, ".add_real"},  add_real,  ar);
    check({tag, ".add_imag"},  add_imag,  ai);
    check({tag, ".sub_real"},  sub_real,  sr);
    check({tag, ".sub_imag"},  sub_imag,  si);
    check({tag, ".out_sat"},   out_sat,   sat);
    check({tag, ".out_last"},  out_last,  lst);
  endtask

  initial begin
    int sent, recv, cyc;
    int ear, eai;
    logic elast;

    rst = 1'b1; in_valid = 1'b0; in_last = 1'b0; inv_mode = 1'b0; scale_mode = 1'b0;
    a_real = '0; a_imag = '0; even_r = '0; even_i = '0; b_real = '0; b_imag = '0;
    out_ready = 1'b1; sat_clr = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
    check("reset.out_valid", out_valid, 0);
    check("reset.in_ready",  in_ready,  1);
    check("reset.add_real",  add_real,  0);
    check("reset.sub_imag",  sub_imag,  0);
    check("reset.out_last",  out_last,  0);
    check("reset.out_sat",   out_sat,   0);
    check("reset.sat_cnt",   sat_cnt,   0);

    // Basic, back-to-back scale modes.
    drive(32, 0, 32, 0, 64, 0, 1'b0, 1'b0, 1'b0);
    drive(32, 0, 32, 0, 64, 0, 1'b0, 1'b1, 1'b1);
    in_valid = 1'b0;
    check("basic.latency", out_valid, 0);
    @(negedge clk);
    expect_out("basic.s0", 48, 0, -16, 0, 1'b0, 1'b0);
    @(negedge clk);
    expect_out("basic.s1", 24, 0, -8, 0, 1'b0, 1'b1);

    // Inverse, back-to-back twiddle modes.
    drive(0, 32, 0, 0, 0, 64, 1'b0, 1'b0, 1'b0);
    drive(0, 32, 0, 0, 0, 64, 1'b1, 1'b0, 1'b0);
    in_valid = 1'b0;
    @(negedge clk);
    expect_out("inv.fwd", -32, 0, 32, 0, 1'b0, 1'b0);
    @(negedge clk);
    expect_out("inv.inv", 32, 0, -32, 0, 1'b0, 1'b0);

    // Rounding half toward +inf.
    drive(1, 0, 0, 0, 32, 0, 1'b0, 1'b0, 1'b0);
    drive(-1, 0, 0, 0, 32, 0, 1'b0, 1'b0, 1'b0);
    in_valid = 1'b0;
    @(negedge clk);
    expect_out("round.pos", 1, 0, 0, 0, 1'b0, 1'b0);
    @(negedge clk);
    expect_out("round.neg", 0, 0, 1, 0, 1'b0, 1'b0);

    // Positive saturation counted on handshake.
    drive(-128, 0, 0, 0, -128, 0, 1'b0, 1'b0, 1'b0);
    in_valid = 1'b0;
    repeat (2) @(negedge clk);
    expect_out("sat.pos", 255, 0, -256, 0, 1'b1, 1'b0);
    check("sat.cnt_before", sat_cnt, 0);
    @(negedge clk);
    check("sat.cnt_after", sat_cnt, 1);

    // Clear on the same cycle as a saturating handshake.
    drive(-128, 0, 0, 0, -128, 0, 1'b0, 1'b0, 1'b0);
    in_valid = 1'b0;
    repeat (2) @(negedge clk);
    check("clr.out_sat", out_sat, 1);
    sat_clr = 1'b1;
    @(negedge clk);
    sat_clr = 1'b0;
    check("clr.sat_cnt", sat_cnt, 0);

    // Negative clamp held under a stall; counts only on release.
    out_ready = 1'b0;
    drive(0, -128, -128, 0, 0, -128, 1'b0, 1'b0, 1'b1);
    in_valid = 1'b0;
    repeat (2) @(negedge clk);
    expect_out("stall.neg", -256, 0, 192, 0, 1'b1, 1'b1);
    check("stall.in_ready_low", in_ready, 0);
    @(negedge clk);
    expect_out("stall.hold", -256, 0, 192, 0, 1'b1, 1'b1);
    check("stall.sat_cnt_hold", sat_cnt, 0);
    out_ready = 1'b1;
    #1;
    check("stall.in_ready_rel", in_ready, 1);
    @(negedge clk);
    check("stall.sat_cnt", sat_cnt, 1);
    check("stall.drained", out_valid, 0);

    // Imaginary-path saturation.
    drive(0, -128, 0, 0, -128, 0, 1'b0, 1'b0, 1'b0);
    in_valid = 1'b0;
    repeat (2) @(negedge clk);
    expect_out("sat.imag", 0, 255, 0, -256, 1'b1, 1'b0);
    @(negedge clk);
    check("sat.imag_cnt", sat_cnt, 2);

    // Backpressure stream: add = a, sub = -a with W = 1, E = 0.
    sent = 0; recv = 0; cyc = 0;
    while (recv < 8 && cyc < 200) begin
      out_ready = 1'($urandom_range(0, 1));
      if (sent < 8) begin
        in_valid   = 1'b1;
        a_real     = 8'(10 * sent + 3);
        a_imag     = 8'(-5 * sent);
        even_r     = '0;
        even_i     = '0;
        b_real     = 8'sd64;
        b_imag     = '0;
        inv_mode   = 1'(sent % 2);
        scale_mode = 1'b0;
        in_last    = (sent % 3 == 2) || (sent == 7);
      end else begin
        in_valid = 1'b0;
      end
      #1;
      check("bp.in_ready", in_ready, (out_valid && !out_ready) ? 0 : 1);
      if (out_valid && out_ready) begin
        ear   = 10 * recv + 3;
        eai   = -5 * recv;
        elast = (recv % 3 == 2) || (recv == 7);
        expect_out($sformatf("bp.s%0d", recv), ear, eai, -ear, -eai, 1'b0, elast);
        recv++;
      end
      if (in_valid && in_ready) sent++;
      cyc++;
      @(negedge clk);
    end
    check("bp.all_received", recv, 8);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("bp.no_dup", out_valid, 0);
    end

    // Reset with three samples in flight.
    drive(-128, 0, 0, 0, -128, 0, 1'b0, 1'b0, 1'b0);
    drive(-128, 0, 0, 0, -128, 0, 1'b0, 1'b0, 1'b1);
    drive(-128, 0, 0, 0, -128, 0, 1'b0, 1'b0, 1'b0);
    in_valid = 1'b0;
    check("rst.pre_valid",   out_valid, 1);
    check("rst.pre_sat_cnt", sat_cnt,   2);
    rst       = 1'b1;
    out_ready = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("rst.out_valid", out_valid, 0);
    check("rst.sat_cnt",   sat_cnt,   0);
    check("rst.in_ready",  in_ready,  1);
    check("rst.add_real",  add_real,  0);
    check("rst.out_sat",   out_sat,   0);
    out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("rst.no_stale", out_valid, 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
